// File: rtl/upsize_arbiter.sv
// ---------------------------------------------------------------------------
// upsize_arbiter
//   Shares the input of a W->2W upsizer among N AXI-stream sources. Grants are
//   issued in units of exactly two accepted beats so every upsized 2W word
//   is built from a single source. In IDLE the grant is a round-robin search
//   starting after rr_ptr. Once the first beat of a pair is accepted, the
//   grant is locked to that source (HALF) until its second beat is accepted.
//
// Parameters
//   W  beat width of each input stream and of the output stream (default 40)
//   N  number of sources, 2..8 (default 4)
//
// Ports
//   aclk        clock, rising edge
//   areset      asynchronous active-high reset
//   in_tdata    N*W packed source beats, source i at [i*W +: W]
//   in_tvalid   per-source valid
//   in_tready   per-source ready (at most one bit high)
//   out_tdata   beat to the upsizer
//   out_tvalid  output valid
//   out_tready  upsizer ready
//   out_tid     index of the source owning the output beat
//
// Configuration
//   UPSIZE_ARB_OUT_REG_EN  defined: the output goes through a 2-entry skid
//                          buffer (1 cycle latency, full throughput).
//                          undefined: combinational output path.
// ---------------------------------------------------------------------------
module upsize_arbiter #(
  parameter int unsigned W = 40,
  parameter int unsigned N = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [N*W-1:0]        in_tdata,
  input  logic [N-1:0]          in_tvalid,
  output logic [N-1:0]          in_tready,
  output logic [W-1:0]          out_tdata,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic [$clog2(N)-1:0]  out_tid
);

  localparam int unsigned IW = $clog2(N);

  typedef enum logic {
    IDLE,
    HALF
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] lock_id;
  logic [IW-1:0] idle_gnt;
  logic          idle_hit;
  logic [IW-1:0] gnt;
  logic          gnt_act;
  logic          src_valid;
  logic [W-1:0]  gnt_data;
  logic          can_accept;
  logic          fire;
  int unsigned   scan_idx;

  // Round-robin search: first valid source after rr_ptr, wrapping modulo N.
  always_comb begin
    idle_gnt = '0;
    idle_hit = 1'b0;
    scan_idx = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      scan_idx = (32'(rr_ptr) + i) % N;
      if (!idle_hit && in_tvalid[IW'(scan_idx)]) begin
        idle_hit = 1'b1;
        idle_gnt = IW'(scan_idx);
      end
    end
  end

  // Grant selection, ready steering and next-state logic.
  always_comb begin
    gnt       = (state == HALF) ? lock_id : idle_gnt;
    gnt_act   = (state == HALF) || idle_hit;
    src_valid = gnt_act && in_tvalid[gnt];
    gnt_data  = in_tdata[gnt*W +: W];
    in_tready = '0;
    if (gnt_act && can_accept && !areset) begin
      in_tready[gnt] = 1'b1;
    end
    fire      = src_valid && can_accept && !areset;
    state_nxt = state;
    case (state)
      IDLE: if (fire) state_nxt = HALF;
      HALF: if (fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state   <= IDLE;
      rr_ptr  <= IW'(N - 1);
      lock_id <= '0;
    end else begin
      state <= state_nxt;
      if (fire && (state == IDLE)) begin
        lock_id <= gnt;
      end
      // Priority rotates only when a pair completes, so a locked source
      // keeps its slot through any number of stall cycles.
      if (fire && (state == HALF)) begin
        rr_ptr <= lock_id;
      end
    end
  end

`ifdef UPSIZE_ARB_OUT_REG_EN
  logic [W-1:0]  buf_data [2];
  logic [IW-1:0] buf_tid  [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          pop;

  // Two entries let a push and a pop overlap at steady state, so the
  // buffer never throttles a stream that the upsizer is draining.
  assign can_accept = (count != 2'd2);
  assign pop        = (count != 2'd0) && out_tready;
  assign out_tvalid = (count != 2'd0);
  assign out_tdata  = buf_data[rd_ptr];
  assign out_tid    = buf_tid[rd_ptr];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_tid[i]  <= '0;
      end
    end else begin
      if (fire) begin
        buf_data[wr_ptr] <= gnt_data;
        buf_tid[wr_ptr]  <= gnt;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({fire, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
`else
  assign can_accept = out_tready;
  assign out_tvalid = src_valid && !areset;
  assign out_tdata  = gnt_data;
  assign out_tid    = gnt;
`endif

endmodule

// File: tb/tb_upsize_arbiter.sv
// ---------------------------------------------------------------------------
// tb_upsize_arbiter
//   Self-checking bench for upsize_arbiter (W=40, N=4). A queue-based model
//   of the sources, the arbitration rules and the optional output buffer
//   predicts ready/valid/data every cycle; a per-source scoreboard and a
//   pairing upsizer model check every output beat.
// ---------------------------------------------------------------------------
module tb_upsize_arbiter;

  localparam int W = 40;
  localparam int N = 4;
`ifdef UPSIZE_ARB_OUT_REG_EN
  localparam bit REG = 1'b1;
`else
  localparam bit REG = 1'b0;
`endif

  logic             aclk = 1'b0;
  logic             areset;
  logic [N*W-1:0]   in_tdata;
  logic [N-1:0]     in_tvalid;
  logic [N-1:0]     in_tready;
  logic [W-1:0]     out_tdata;
  logic             out_tvalid;
  logic             out_tready;
  logic [1:0]       out_tid;

  upsize_arbiter #(.W(W), .N(N)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .in_tdata   (in_tdata),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tid    (out_tid)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int           tid;
    logic [W-1:0] data;
  } ent_t;

  // Stimulus / model state
  logic [W-1:0]   src_q [N][$];
  logic [W-1:0]   exp_q [N][$];
  bit             en [N];
  logic [N-1:0]   vv;
  ent_t           mq [$];
  bit             m_busy;
  int             m_lock;
  int             m_last;
  bit             rst_drive;
  bit             rdy_drive;
  logic [N-1:0]   last_rdy;

  // Upsizer model and logs
  bit             half;
  int             half_tid;
  logic [W-1:0]   half_data;
  logic [2*W-1:0] words [$];
  int             pair_tids [$];
  int             out_cycles [$];
  int             cyc;

  int             total;
  int             passed;
  int             fails;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_beat();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_lock = 0;
    m_last = N - 1;
    mq.delete();
    for (int i = 0; i < N; i++) exp_q[i].delete();
    half = 1'b0;
  endtask

  task automatic clear_logs();
    words.delete();
    pair_tids.delete();
    out_cycles.delete();
  endtask

  function automatic int pending();
    int p;
    p = mq.size();
    for (int i = 0; i < N; i++) if (en[i]) p += src_q[i].size();
    return p;
  endfunction

  function automatic int sb_left();
    int p;
    p = 0;
    for (int i = 0; i < N; i++) p += exp_q[i].size();
    return p;
  endfunction

  task automatic cycle();
    int           g;
    bit           can;
    logic [N-1:0] er;
    bit           eov;
    int           etid;
    logic [W-1:0] edat;
    bit           sb_hit;
    int           sb_tid;
    logic [W-1:0] sb_dat;
    bit           fire_in;
    logic [W-1:0] beat;

    @(negedge aclk);
    areset     = rst_drive;
    out_tready = rdy_drive;
    for (int i = 0; i < N; i++) begin
      vv[i]              = en[i] && (src_q[i].size() > 0);
      in_tvalid[i]       = vv[i];
      in_tdata[i*W +: W] = vv[i] ? src_q[i][0] : '0;
    end
    #1;

    g    = -1;
    can  = 1'b0;
    er   = '0;
    eov  = 1'b0;
    etid = 0;
    edat = '0;
    if (!rst_drive) begin
      if (m_busy) g = m_lock;
      else begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (m_last + k) % N;
          if (g < 0 && vv[j]) g = j;
        end
      end
      can = REG ? (mq.size() < 2) : rdy_drive;
      if (g >= 0 && can) er[g] = 1'b1;
      if (REG) begin
        eov = mq.size() > 0;
        if (eov) begin
          etid = mq[0].tid;
          edat = mq[0].data;
        end
      end else begin
        eov = (g >= 0) && vv[g];
        if (eov) begin
          etid = g;
          edat = src_q[g][0];
        end
      end
    end

    check("in_tready", 96'(in_tready), 96'(er));
    check("out_tvalid", 96'(out_tvalid), 96'(eov));
    if (eov) begin
      check("out_tid", 96'(out_tid), 96'(etid));
      check("out_tdata", 96'(out_tdata), 96'(edat));
    end
    last_rdy = in_tready;

    sb_hit  = !rst_drive && (out_tvalid === 1'b1) && rdy_drive;
    sb_tid  = int'(out_tid);
    sb_dat  = out_tdata;
    fire_in = !rst_drive && (g >= 0) && can && vv[g];

    @(posedge aclk);
    if (rst_drive) begin
      model_reset();
    end else begin
      if (REG && mq.size() > 0 && rdy_drive) void'(mq.pop_front());
      if (fire_in) begin
        beat = src_q[g].pop_front();
        exp_q[g].push_back(beat);
        if (REG) mq.push_back('{tid: g, data: beat});
        if (m_busy) begin
          m_busy = 1'b0;
          m_last = m_lock;
        end else begin
          m_busy = 1'b1;
          m_lock = g;
        end
      end
      if (sb_hit) begin
        out_cycles.push_back(cyc);
        if (exp_q[sb_tid].size() == 0) begin
          check("sb_unexpected_beat", 96'(exp_q[sb_tid].size()), 96'(1));
        end else begin
          check("sb_data", 96'(sb_dat), 96'(exp_q[sb_tid].pop_front()));
        end
        if (!half) begin
          half      = 1'b1;
          half_tid  = sb_tid;
          half_data = sb_dat;
          pair_tids.push_back(sb_tid);
        end else begin
          check("pair_same_tid", 96'(sb_tid), 96'(half_tid));
          words.push_back({half_data, sb_dat});
          half = 1'b0;
        end
      end
    end
    cyc++;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (pending() > 0 && n < limit) begin
      cycle();
      n++;
    end
    check("drain_done", 96'(pending()), 96'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] d1, d2, d3;
    total = 0; passed = 0; fails = 0; cyc = 0;
    rst_drive = 1'b1; rdy_drive = 1'b1;
    areset = 1'b1; out_tready = 1'b1; in_tvalid = '0; in_tdata = '0;
    for (int i = 0; i < N; i++) en[i] = 1'b1;
    model_reset();
    clear_logs();

    // Reset with every source valid
    src_q[0].push_back("ABCDE"); src_q[0].push_back("FGHIJ");
    src_q[2].push_back("KLMON"); src_q[2].push_back("PQRST");
    src_q[1].push_back(rnd_beat()); src_q[1].push_back(rnd_beat());
    src_q[3].push_back(rnd_beat()); src_q[3].push_back(rnd_beat());
    repeat (6) begin
      cycle();
      check("rst_in_tready", 96'(last_rdy), 96'(0));
      check("rst_out_tvalid", 96'(out_tvalid), 96'(0));
    end

    // Back-to-back pairs from src0 then src2
    src_q[1].delete(); src_q[3].delete();
    en[1] = 1'b0; en[3] = 1'b0;
    rst_drive = 1'b0;
    clear_logs();
    drain(40);
    check("b2b_pairs", 96'(words.size()), 96'(2));
    if (words.size() == 2 && out_cycles.size() == 4) begin
      check("b2b_word0", 96'(words[0]), 96'({"ABCDE", "FGHIJ"}));
      check("b2b_word1", 96'(words[1]), 96'({"KLMON", "PQRST"}));
      check("b2b_tid0", 96'(pair_tids[0]), 96'(0));
      check("b2b_tid1", 96'(pair_tids[1]), 96'(2));
      check("b2b_no_bubble", 96'(out_cycles[3] - out_cycles[0]), 96'(3));
    end

    // Lock: src1 stalls mid-pair while src3 waits
    clear_logs();
    for (int i = 0; i < N; i++) en[i] = 1'b1;
    en[3] = 1'b0;
    src_q[1].push_back(rnd_beat()); src_q[1].push_back(rnd_beat());
    src_q[3].push_back(rnd_beat()); src_q[3].push_back(rnd_beat());
    cycle();
    en[1] = 1'b0; en[3] = 1'b1;
    repeat (5) begin
      cycle();
      check("lock_rdy3", 96'(last_rdy[3]), 96'(0));
    end
    en[1] = 1'b1;
    drain(20);
    check("lock_pairs", 96'(pair_tids.size()), 96'(2));
    if (pair_tids.size() == 2) begin
      check("lock_first", 96'(pair_tids[0]), 96'(1));
      check("lock_next", 96'(pair_tids[1]), 96'(3));
    end

    // Fairness: all sources continuously valid
    clear_logs();
    for (int i = 0; i < N; i++) repeat (4) src_q[i].push_back(rnd_beat());
    repeat (16) cycle();
    drain(20);
    check("fair_pairs", 96'(pair_tids.size()), 96'(8));
    if (pair_tids.size() == 8) begin
      for (int i = 0; i < 8; i++) check("fair_order", 96'(pair_tids[i]), 96'(i % N));
    end

    // Backpressure: out_tready toggling each cycle
    clear_logs();
    for (int i = 0; i < N; i++) repeat (2 * $urandom_range(1, 3)) src_q[i].push_back(rnd_beat());
    for (int c = 0; c < 20; c++) begin
      rdy_drive = (c % 2) == 1;
      cycle();
    end
    rdy_drive = 1'b1;
    drain(100);
    check("bp_sb_empty", 96'(sb_left()), 96'(0));
    check("bp_no_half", 96'(half), 96'(0));

    // Random valids and random backpressure
    repeat (3) begin
      for (int i = 0; i < N; i++) repeat (2 * $urandom_range(1, 4)) src_q[i].push_back(rnd_beat());
      repeat (40) begin
        rdy_drive = ($urandom % 4) != 0;
        for (int i = 0; i < N; i++) en[i] = ($urandom % 5) != 0;
        cycle();
      end
      rdy_drive = 1'b1;
      for (int i = 0; i < N; i++) en[i] = 1'b1;
      drain(200);
      check("rnd_sb_empty", 96'(sb_left()), 96'(0));
    end

    // Reset in the middle of a src2 pair
    clear_logs();
    for (int i = 0; i < N; i++) en[i] = 1'b0;
    en[2] = 1'b1;
    d1 = rnd_beat(); d2 = rnd_beat(); d3 = rnd_beat();
    src_q[2].push_back(d1); src_q[2].push_back(d2);
    cycle();
    rst_drive = 1'b1;
    repeat (2) cycle();
    rst_drive = 1'b0;
    clear_logs();
    src_q[2].push_back(d3);
    src_q[0].push_back(rnd_beat()); src_q[0].push_back(rnd_beat());
    en[0] = 1'b1;
    drain(30);
    check("mrst_pairs", 96'(pair_tids.size()), 96'(2));
    if (pair_tids.size() == 2 && words.size() == 2) begin
      check("mrst_first_src0", 96'(pair_tids[0]), 96'(0));
      check("mrst_then_src2", 96'(pair_tids[1]), 96'(2));
      check("mrst_src2_word", 96'(words[1]), 96'({d2, d3}));
    end
    check("mrst_sb_empty", 96'(sb_left()), 96'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/upsize_arbiter.md
UPSIZE_ARBITER -- requirements
Module: upsize_arbiter

Interface
REQ-001 Parameter W, default 40: beat width of every input stream and of the shared output stream.
REQ-002 Parameter N, default 4: number of requesting streams; legal range 2..8.
REQ-003 aclk  input  1  single clock; all logic on rising edge.
REQ-004 areset  input  1  asynchronous, active-high reset.
REQ-005 in_tdata  input  N*W  packed source beats; source i occupies bits [i*W +: W].
REQ-006 in_tvalid  input  N  per-source valid.
REQ-007 in_tready  output  N  per-source ready.
REQ-008 out_tdata  output  W  beat forwarded to the shared W->2W upsizer.
REQ-009 out_tvalid  output  1  output valid.
REQ-010 out_tready  input  1  upsizer ready.
REQ-011 out_tid  output  $clog2(N)  index of the source owning the current output beat.

Function
REQ-012 The block SHALL share one upsizer input among N AXI-stream sources, granting in units of exactly 2 accepted beats so that every 2W upsized word comes from a single source.
REQ-013 A beat SHALL count as transferred on a source only when in_tvalid[i] & in_tready[i] at a rising edge, and on the output only when out_tvalid & out_tready.
REQ-014 The FSM SHALL have two states: IDLE (no pair in progress) and HALF (first beat of a pair accepted, grant locked).
REQ-015 In IDLE the grant SHALL be combinational: the first source with in_tvalid high, searching from rr_ptr+1 upward modulo N.
REQ-016 On first-beat acceptance in IDLE, the block SHALL move IDLE->HALF and register the granted index as lock_id.
REQ-017 In HALF, only source lock_id SHALL see in_tready; all other in_tready bits SHALL be 0, whatever their valids.
REQ-018 On second-beat acceptance in HALF, the block SHALL move HALF->IDLE and set rr_ptr <= lock_id.
REQ-019 HALF SHALL persist indefinitely while lock_id holds in_tvalid low; no timeout and no beat is dropped.
REQ-020 Only the granted source SHALL have in_tready = downstream-can-accept; at most one in_tready bit SHALL be high in any cycle.
REQ-021 out_tdata and out_tid SHALL carry the granted source's data and index; out_tvalid SHALL equal that source's in_tvalid, gated per REQ-027.
REQ-022 Throughput SHALL be one beat per cycle with no bubble between the two beats of a pair or between consecutive pairs.
REQ-023 A source with in_tvalid low in IDLE SHALL never be granted. No valid anywhere SHALL give out_tvalid 0 and all in_tready 0.
REQ-024 A source holding valid continuously SHALL be granted within N-1 pairs of other sources (round-robin fairness).
REQ-025 A source deasserting valid in IDLE before acceptance SHALL lose nothing. Arbitration re-evaluates every IDLE cycle.

Reset
REQ-026 While areset is high: state = IDLE, rr_ptr = N-1 (source 0 has first priority), lock_id = 0, out_tvalid = 0, all in_tready = 0, any registered output slot emptied.
REQ-027 Assertion of areset mid-pair SHALL discard the pending half pair. Operation SHALL resume at the first rising edge after areset deasserts.

Configuration
REQ-028 Macro UPSIZE_ARB_OUT_REG_EN defined: the output SHALL pass through a 2-entry skid buffer. Latency is 1 cycle and full throughput is kept. Downstream-can-accept = buffer not full. out_* come from registers.
REQ-029 Macro UPSIZE_ARB_OUT_REG_EN undefined: the output path SHALL be combinational with 0 latency. Downstream-can-accept = out_tready.

Verification (W=40, N=4, both macro settings)
REQ-030 Reset: areset high 6 cycles with all valids high -> out_tvalid=0 and in_tready=0000 throughout.
REQ-031 Back-to-back: src0 sends "ABCDE","FGHIJ" and src2 sends "KLMON","PQRST", all valid together, out_tready=1 -> output order ABCDE,FGHIJ (tid 0) then KLMON,PQRST (tid 2). 4 consecutive transfers; upsizer emits "ABCDEFGHIJ","KLMONPQRST".
REQ-032 Lock: src1 first beat accepted, then src1 valid low 5 cycles while src3 valid high -> in_tready[3]=0 for all 5 cycles. src1 second beat then completes the pair, and src3 is granted next.
REQ-033 Fairness: all four valids held high for 16 cycles -> grants in pair order 0,1,2,3,0,1,2,3. No source waits more than 6 beats.
REQ-034 Backpressure: out_tready pattern toggling each cycle for 20 cycles -> no beat lost, duplicated or reordered per source. A scoreboard of per-source queues matches every output pair.
REQ-035 Reset mid-pair: areset pulsed after first beat of src2 -> after release, FSM in IDLE, src0 granted first, and the src2 half pair is not forwarded again.
